bist_controller: RTL and testbench
==================================

BIST_CONTROLLER -- requirements
Module: bist_controller

Interface
REQ-001 Parameter PAT_W, default 8: width of the pattern driven to the circuit under test (CUT), 1..16.
REQ-002 Parameter N_PAT, default 200: number of patterns applied per test, 1..65535.
REQ-003 Parameter SETTLE_CYC, default 2: cycles waited after the last pattern so CUT and MISR latency drains, 0..15.
REQ-004 Parameter LFSR_SEED, default 16'hACE1: LFSR seed; must be nonzero, elaboration error if zero.
REQ-005 Parameter GOLDEN, default 24'h000000: expected 24-bit MISR signature.
REQ-006 CLK  in  1  single clock; all state updates on rising edge.
REQ-007 RST  in  1  asynchronous, active-low reset.
REQ-008 start  in  1  level; begins a test when sampled high in IDLE or DONE.
REQ-009 abort  in  1  level; cancels a test in progress.
REQ-010 misr_sig  in  24  signature from the MISR (its hf output).
REQ-011 pattern  out  PAT_W  test pattern to the CUT, equal to lfsr[PAT_W-1:0].
REQ-012 pat_valid  out  1  high in every RUN cycle.
REQ-013 misr_rst  out  1  active-high MISR reseed/hold, matching the MISR RST polarity.
REQ-014 bist_end  out  1  active-high MISR freeze, drives the MISR bist_end.
REQ-015 busy  out  1  high in INIT, RUN, SETTLE and COMPARE.
REQ-016 done  out  1  high in DONE only.
REQ-017 pass  out  1  compare result; valid while done=1, otherwise 0.

Function
REQ-018 FSM states: IDLE, INIT, RUN, SETTLE, COMPARE, DONE.
- IDLE->INIT when start=1.
- INIT->RUN unconditionally after one cycle.
- RUN->SETTLE after N_PAT RUN cycles.
- SETTLE->COMPARE after SETTLE_CYC cycles; with SETTLE_CYC=0, RUN goes directly to COMPARE.
- COMPARE->DONE after one cycle.
- DONE->INIT when start=1; otherwise DONE holds.
REQ-019 INIT: load lfsr with LFSR_SEED, clear the pattern counter, assert misr_rst.
REQ-020 misr_rst=1 in IDLE and INIT; misr_rst=0 in all other states.
REQ-021 bist_end=1 in COMPARE and DONE; bist_end=0 in all other states.
REQ-022 LFSR behaviour:
- 16-bit Fibonacci, right shift.
- fb = l[0]^l[2]^l[3]^l[5]; next = {fb, l[15:1]}; maximal period 65535.
- Advances on every RUN clock edge only; holds in all other states.
REQ-023 The pattern counter is 16-bit, increments once per RUN cycle, never wraps, and is compared against N_PAT-1 to leave RUN.
REQ-024 The settle counter is 4-bit, cleared on entry to SETTLE.
REQ-025 At the COMPARE clock edge, pass is registered as (misr_sig == GOLDEN); pass is held through DONE and cleared on leaving DONE.
REQ-026 abort=1 in INIT, RUN, SETTLE or COMPARE returns the FSM to IDLE on the next edge with done=0 and pass=0.
REQ-027 abort is ignored in IDLE and DONE.
REQ-028 If abort and start are both high in DONE, start wins.
REQ-029 start deasserting during a test has no effect.
REQ-030 Latency from the start-sampling edge to done=1 is N_PAT+SETTLE_CYC+2 cycles.

Reset
REQ-031 RST=0 asynchronously forces the following, whatever the state, including mid-test:
- state IDLE, lfsr=LFSR_SEED, both counters 0;
- pattern=LFSR_SEED[PAT_W-1:0] (8'hE1 by default);
- pat_valid=0, misr_rst=1, bist_end=0, busy=0, done=0, pass=0.
REQ-032 After RST returns high, the first state change happens only on a later rising edge with start=1.

Structure
REQ-033 A shared package bist_pkg holds the state enum, the LFSR tap constants, the default seed 16'hACE1 and the signature width 24.
REQ-034 The LFSR is one sub-module, bist_lfsr, with ports CLK, RST, load, en, q[15:0]; the controller instantiates it once.

Verification
REQ-035 Reset check: assert RST=0 -> pattern=8'hE1, misr_rst=1, bist_end=0, busy=done=pass=0.
REQ-036 Sequence check: N_PAT=4, start=1 -> pat_valid high for exactly 4 cycles; patterns 8'hE1, 8'h70, then the next two LFSR values computed per REQ-022.
REQ-037 Latency and pass check: N_PAT=4, SETTLE_CYC=2, misr_sig=GOLDEN -> done=1 exactly 8 cycles after the start edge, pass=1, bist_end=1.
REQ-038 Fail check: same run with misr_sig=GOLDEN^24'h000001 -> done=1, pass=0.
REQ-039 Abort check: abort=1 on the 2nd RUN cycle -> IDLE next edge, misr_rst=1, done=0; a following start reruns from pattern 8'hE1.
REQ-040 Async reset and restart check:
- RST=0 mid-SETTLE -> outputs take reset values immediately, without waiting for a clock edge.
- start held high in DONE -> INIT, then RUN, with pass cleared.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST controller and its pattern LFSR.
package bist_pkg;

  localparam int unsigned LFSR_W = 16;
  localparam int unsigned SIG_W  = 24;
  localparam int unsigned SCNT_W = 4;

  // Feedback taps l[0]^l[2]^l[3]^l[5] of the right-shifting Fibonacci LFSR.
  localparam logic [LFSR_W-1:0] LFSR_TAPS         = 16'h002D;
  localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT = 16'hACE1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_RUN,
    ST_SETTLE,
    ST_COMPARE,
    ST_DONE
  } bist_state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
    return {^(l & LFSR_TAPS), l[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/bist_lfsr.sv
// 16-bit maximal-length pattern LFSR with synchronous seed load and step enable.
module bist_lfsr
  import bist_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              load,
  input  logic              en,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = SEED;
    end else if (en) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/bist_controller.sv
// Logic BIST sequencer: drives LFSR patterns into the CUT, lets the MISR drain,
// then compares the captured signature against a golden value.
module bist_controller
  import bist_pkg::*;
#(
  parameter int unsigned       PAT_W      = 8,
  parameter int unsigned       N_PAT      = 200,
  parameter int unsigned       SETTLE_CYC = 2,
  parameter logic [LFSR_W-1:0] LFSR_SEED  = LFSR_SEED_DEFAULT,
  parameter logic [SIG_W-1:0]  GOLDEN     = 24'h000000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             abort,
  input  logic [SIG_W-1:0] misr_sig,
  output logic [PAT_W-1:0] pattern,
  output logic             pat_valid,
  output logic             misr_rst,
  output logic             bist_end,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  localparam logic [LFSR_W-1:0] PAT_LAST    = LFSR_W'(N_PAT - 1);
  localparam logic [SCNT_W-1:0] SETTLE_LAST = (SETTLE_CYC == 0) ? '0 : SCNT_W'(SETTLE_CYC - 1);

  if (LFSR_SEED == '0) begin : g_bad_seed
    $error("bist_controller: LFSR_SEED must be nonzero");
  end
  if (PAT_W < 1 || PAT_W > 16) begin : g_bad_pat_w
    $error("bist_controller: PAT_W must be 1..16");
  end
  if (N_PAT < 1 || N_PAT > 65535) begin : g_bad_n_pat
    $error("bist_controller: N_PAT must be 1..65535");
  end
  if (SETTLE_CYC > 15) begin : g_bad_settle
    $error("bist_controller: SETTLE_CYC must be 0..15");
  end

  bist_state_e       state_q, state_d;
  logic [LFSR_W-1:0] pat_cnt_q, pat_cnt_d;
  logic [SCNT_W-1:0] settle_cnt_q, settle_cnt_d;
  logic              pass_q, pass_d;
  logic              pat_valid_q, misr_rst_q, bist_end_q, busy_q, done_q;
  logic [LFSR_W-1:0] lfsr_q;
  logic              unused_lfsr_c;

  bist_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .CLK  (CLK),
    .RST  (RST),
    .load (state_q == ST_INIT),
    .en   (state_q == ST_RUN),
    .q    (lfsr_q)
  );

  // Next state, counters and compare result.
  always_comb begin
    state_d      = state_q;
    pat_cnt_d    = pat_cnt_q;
    settle_cnt_d = settle_cnt_q;
    pass_d       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_INIT;
      end
      ST_INIT: begin
        pat_cnt_d = '0;
        state_d   = abort ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        if (pat_cnt_q != '1) pat_cnt_d = pat_cnt_q + LFSR_W'(1);
        settle_cnt_d = '0;
        if (abort) begin
          state_d = ST_IDLE;
        end else if (pat_cnt_q == PAT_LAST) begin
          state_d = (SETTLE_CYC == 0) ? ST_COMPARE : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        settle_cnt_d = settle_cnt_q + SCNT_W'(1);
        if (abort) begin
          state_d = ST_IDLE;
        end else if (settle_cnt_q == SETTLE_LAST) begin
          state_d = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
          pass_d  = (misr_sig == GOLDEN);
        end
      end
      ST_DONE: begin
        // start takes priority over abort; abort alone is ignored here.
        if (start) begin
          state_d = ST_INIT;
        end else begin
          pass_d = pass_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= ST_IDLE;
      pat_cnt_q    <= '0;
      settle_cnt_q <= '0;
      pass_q       <= 1'b0;
      pat_valid_q  <= 1'b0;
      misr_rst_q   <= 1'b1;
      bist_end_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pat_cnt_q    <= pat_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      pass_q       <= pass_d;
      pat_valid_q  <= (state_d == ST_RUN);
      misr_rst_q   <= (state_d == ST_IDLE) || (state_d == ST_INIT);
      bist_end_q   <= (state_d == ST_COMPARE) || (state_d == ST_DONE);
      busy_q       <= (state_d == ST_INIT) || (state_d == ST_RUN) ||
                      (state_d == ST_SETTLE) || (state_d == ST_COMPARE);
      done_q       <= (state_d == ST_DONE);
    end
  end

  // Upper LFSR bits only feed the feedback path, not the CUT.
  assign unused_lfsr_c = ^lfsr_q;

  assign pattern   = lfsr_q[PAT_W-1:0];
  assign pat_valid = pat_valid_q;
  assign misr_rst  = misr_rst_q;
  assign bist_end  = bist_end_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;

endmodule

// File: tb/tb_bist_controller.sv
// Randomized self-checking bench for bist_controller against a cycle-phase reference model.
module tb_bist_controller;

  localparam int unsigned PAT_W      = 8;
  localparam int unsigned N_PAT      = 4;
  localparam int unsigned SETTLE_CYC = 2;
  localparam logic [23:0] GOLDEN_SIG = 24'h5A3C96;
  localparam int          DONE_J     = N_PAT + SETTLE_CYC + 2;
  localparam logic [15:0] REF_SEED   = 16'hACE1;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [23:0]      misr_sig = '0;
  logic [PAT_W-1:0] pattern;
  logic             pat_valid, misr_rst, bist_end, busy, done, pass;

  int n_cmp = 0;
  int n_err = 0;

  bist_controller #(
    .PAT_W      (PAT_W),
    .N_PAT      (N_PAT),
    .SETTLE_CYC (SETTLE_CYC),
    .LFSR_SEED  (REF_SEED),
    .GOLDEN     (GOLDEN_SIG)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .abort     (abort),
    .misr_sig  (misr_sig),
    .pattern   (pattern),
    .pat_valid (pat_valid),
    .misr_rst  (misr_rst),
    .bist_end  (bist_end),
    .busy      (busy),
    .done      (done),
    .pass      (pass)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // LFSR value after k steps from the seed, straight from the tap equation.
  function automatic logic [15:0] ref_lfsr(input int k);
    logic [15:0] l;
    l = REF_SEED;
    for (int i = 0; i < k; i++) l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    return l;
  endfunction

  // {pat_valid, misr_rst, bist_end, busy, done} for j edges after the start edge (j<0: idle).
  function automatic logic [4:0] ref_flags(input int j);
    if (j < 0)                                 return 5'b01000;
    if (j == 0)                                return 5'b01010;
    if (j <= int'(N_PAT))                      return 5'b10010;
    if (j <= int'(N_PAT + SETTLE_CYC))         return 5'b00010;
    if (j == int'(N_PAT + SETTLE_CYC) + 1)     return 5'b00110;
    return 5'b00101;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_flags(input string tag, input int j);
    check({tag, ".flags"}, 32'({pat_valid, misr_rst, bist_end, busy, done}), 32'(ref_flags(j)));
  endtask

  task automatic check_cycle(input int j, input bit exp_pass);
    logic [15:0] l;
    check_flags($sformatf("cyc%0d", j), j);
    check($sformatf("cyc%0d.pass", j), 32'(pass), (j >= DONE_J) ? 32'(exp_pass) : 32'd0);
    if (j >= 1) begin
      l = ref_lfsr(imin(j - 1, int'(N_PAT)));
      check($sformatf("cyc%0d.pattern", j), 32'(pattern), 32'(l[PAT_W-1:0]));
    end
    if (j == 1) check("first_pattern", 32'(pattern), 32'h0000_00E1);
    if (j == 2) check("second_pattern", 32'(pattern), 32'h0000_0070);
  endtask

  // One test from IDLE or DONE; abort_j >= 0 raises abort while j edges past the start edge.
  task automatic run_test(input bit match, input logic [23:0] flip, input int abort_j);
    logic [15:0] l;
    start    = 1'b1;
    abort    = 1'($urandom_range(0, 1));
    misr_sig = 24'($urandom);
    tick();
    for (int j = 0; j <= DONE_J; j++) begin
      check_cycle(j, match);
      if (j == DONE_J) break;
      start    = 1'($urandom_range(0, 1));
      abort    = (j == abort_j);
      misr_sig = (j == DONE_J - 1) ? (match ? GOLDEN_SIG : GOLDEN_SIG ^ flip) : 24'($urandom);
      tick();
      if (j == abort_j) begin
        check_flags($sformatf("abort%0d", j), -1);
        check($sformatf("abort%0d.pass", j), 32'(pass), 32'd0);
        if (j >= 1) begin
          l = ref_lfsr(imin(j, int'(N_PAT)));
          check($sformatf("abort%0d.pattern", j), 32'(pattern), 32'(l[PAT_W-1:0]));
        end
        start = 1'b0;
        abort = 1'b0;
        return;
      end
    end
    start = 1'b0;
    repeat (2) begin
      abort    = 1'($urandom_range(0, 1));
      misr_sig = 24'($urandom);
      tick();
      check_cycle(DONE_J, match);
    end
    abort = 1'b0;
  endtask

  initial begin
    #12;
    check_flags("reset", -1);
    check("reset.pattern", 32'(pattern), 32'h0000_00E1);
    check("reset.pass", 32'(pass), 32'd0);
    #1 RST = 1'b1;

    abort = 1'b1;
    repeat (3) begin
      tick();
      check_flags("idle_hold", -1);
      check("idle_hold.pattern", 32'(pattern), 32'h0000_00E1);
    end
    abort = 1'b0;

    run_test(1'b1, 24'h0, -1);
    run_test(1'b0, 24'h000001, -1);
    run_test(1'b1, 24'h0, 2);
    run_test(1'b1, 24'h0, -1);

    // Asynchronous reset while settling.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (N_PAT + 1) tick();
    check_flags("pre_async", int'(N_PAT) + 1);
    #2 RST = 1'b0;
    #1;
    check_flags("async_rst", -1);
    check("async_rst.pattern", 32'(pattern), 32'h0000_00E1);
    check("async_rst.pass", 32'(pass), 32'd0);
    #2 RST = 1'b1;
    tick();
    check_flags("post_async", -1);

    repeat (25) begin
      bit          m;
      logic [23:0] f;
      int          aj;
      m  = 1'($urandom_range(0, 1));
      f  = 24'(1) << $urandom_range(0, 23);
      aj = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, DONE_J - 1)) : -1;
      run_test(m, f, aj);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
